// File: rtl/sprite_motion_ctl_pkg.sv
// Shared definitions for the player sprite motion controller: VGA timing bus layout,
// vertical motion state encoding and default screen constants.
package sprite_motion_ctl_pkg;

  // Bus layout, MSB first: hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk
  localparam int unsigned VGA_BUS_W = 26;
  typedef logic [VGA_BUS_W-1:0] vga_bus_t;

  typedef enum logic [1:0] {
    SPR_GROUND = 2'd0,
    SPR_RISE   = 2'd1,
    SPR_FALL   = 2'd2
  } spr_state_e;

  localparam int unsigned DEF_RECT_WIDTH = 48;
  localparam int unsigned DEF_X_START    = 400;
  localparam int unsigned DEF_X_MIN      = 0;
  localparam int unsigned DEF_X_MAX      = 800;
  localparam int unsigned DEF_Y_GROUND   = 500;
  localparam int unsigned DEF_X_STEP     = 4;
  localparam int unsigned DEF_JUMP_V     = 16;
  localparam int unsigned DEF_GRAVITY    = 1;
  localparam int unsigned DEF_V_MAX      = 16;
  localparam int unsigned DEF_TICK_LINE  = 600;

  function automatic logic [10:0] bus_hcount(input vga_bus_t b);
    return b[25:15];
  endfunction

  function automatic logic [10:0] bus_vcount(input vga_bus_t b);
    return b[12:2];
  endfunction

  function automatic vga_bus_t bus_pack(input logic [10:0] h, input logic [10:0] v);
    return {h, 2'b00, v, 2'b00};
  endfunction

endpackage

// File: rtl/sprite_motion_ctl_frame_tick_gen.sv
// Registered one-clock pulse at the start of a chosen scan line; usable by any
// logic that must advance exactly once per frame.
module frame_tick_gen
  import sprite_motion_ctl_pkg::*;
#(
  parameter int unsigned TICK_LINE = DEF_TICK_LINE
) (
  input  logic     clk,
  input  logic     rst,
  input  vga_bus_t vga_bus_i,
  output logic     tick_o
);

  logic match;
  logic match_q;
  logic tick_q;
  logic unused_bus_bits;

  assign unused_bus_bits = ^{vga_bus_i[14:13], vga_bus_i[1:0]};

  always_comb begin
    match = (bus_vcount(vga_bus_i) == 11'(TICK_LINE)) && (bus_hcount(vga_bus_i) == '0);
  end

  // Edge-qualified so a stalled timing bus cannot produce a second tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      match_q <= match;
      tick_q  <= match & ~match_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/sprite_motion_ctl.sv
// Frame-synchronous player sprite controller: horizontal stepping plus a
// jump/gravity state machine, all updated once per frame on the blanking tick.
module sprite_motion_ctl
  import sprite_motion_ctl_pkg::*;
#(
  parameter int unsigned RECT_WIDTH = DEF_RECT_WIDTH,
  parameter int unsigned X_START    = DEF_X_START,
  parameter int unsigned X_MIN      = DEF_X_MIN,
  parameter int unsigned X_MAX      = DEF_X_MAX,
  parameter int unsigned Y_GROUND   = DEF_Y_GROUND,
  parameter int unsigned X_STEP     = DEF_X_STEP,
  parameter int unsigned JUMP_V     = DEF_JUMP_V,
  parameter int unsigned GRAVITY    = DEF_GRAVITY,
  parameter int unsigned V_MAX      = DEF_V_MAX,
  parameter int unsigned TICK_LINE  = DEF_TICK_LINE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VGA_BUS_W-1:0] vga_bus_in,
  input  logic                 game_en,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_jump,
  output logic [9:0]           xpos,
  output logic [9:0]           ypos,
  output logic                 mirror,
  output logic                 module_en,
  output logic                 airborne
);

  localparam int unsigned X_RIGHT = X_MAX - RECT_WIDTH;

  logic       tick;
  spr_state_e state_q, state_d;
  logic [5:0] vel_q, vel_d;
  logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic       mirror_q, mirror_d, module_en_q, module_en_d, airborne_q, airborne_d;
  logic       jump_req_q, jump_req_d, btn_jump_q;
  logic       jump_rise;
  logic [10:0] x_wide, y_wide, x_sum, y_sum;
  logic [6:0]  v_sum, v_next;

  frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .vga_bus_i(vga_bus_in),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    vel_d       = vel_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    mirror_d    = mirror_q;
    module_en_d = module_en_q;
    airborne_d  = airborne_q;
    jump_rise   = btn_jump & ~btn_jump_q;
    jump_req_d  = jump_req_q | jump_rise;
    x_wide      = {1'b0, xpos_q};
    y_wide      = {1'b0, ypos_q};
    x_sum       = x_wide + 11'(X_STEP);
    v_sum       = {1'b0, vel_q} + 7'(GRAVITY);
    v_next      = (v_sum > 7'(V_MAX)) ? 7'(V_MAX) : v_sum;
    y_sum       = y_wide + {4'b0, v_next};

    if (tick) begin
      // A request arriving in the tick clock is consumed here; otherwise it is dropped.
      jump_req_d  = 1'b0;
      module_en_d = game_en;
      if (game_en) begin
        if (btn_left && !btn_right) begin
          xpos_d   = (x_wide < 11'(X_MIN + X_STEP)) ? 10'(X_MIN) : 10'(x_wide - 11'(X_STEP));
          mirror_d = 1'b1;
        end else if (btn_right && !btn_left) begin
          xpos_d   = (x_sum > 11'(X_RIGHT)) ? 10'(X_RIGHT) : x_sum[9:0];
          mirror_d = 1'b0;
        end

        case (state_q)
          SPR_GROUND: begin
            if (jump_req_q || jump_rise) begin
              state_d = SPR_RISE;
              vel_d   = 6'(JUMP_V);
            end
          end
          SPR_RISE: begin
            if (y_wide < {5'b0, vel_q}) begin
              ypos_d  = '0;
              vel_d   = '0;
              state_d = SPR_FALL;
            end else begin
              ypos_d = ypos_q - {4'b0, vel_q};
              vel_d  = (vel_q > 6'(GRAVITY)) ? vel_q - 6'(GRAVITY) : '0;
              if (vel_d == '0) state_d = SPR_FALL;
            end
          end
          SPR_FALL: begin
            if (y_sum >= 11'(Y_GROUND)) begin
              ypos_d  = 10'(Y_GROUND);
              vel_d   = '0;
              state_d = SPR_GROUND;
            end else begin
              ypos_d = y_sum[9:0];
              vel_d  = v_next[5:0];
            end
          end
          default: state_d = SPR_GROUND;
        endcase
      end
      airborne_d = (state_d != SPR_GROUND);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SPR_GROUND;
      vel_q       <= '0;
      xpos_q      <= 10'(X_START);
      ypos_q      <= 10'(Y_GROUND);
      mirror_q    <= 1'b0;
      module_en_q <= 1'b0;
      airborne_q  <= 1'b0;
      jump_req_q  <= 1'b0;
      btn_jump_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      mirror_q    <= mirror_d;
      module_en_q <= module_en_d;
      airborne_q  <= airborne_d;
      jump_req_q  <= jump_req_d;
      btn_jump_q  <= btn_jump;
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign mirror    = mirror_q;
  assign module_en = module_en_q;
  assign airborne  = airborne_q;

endmodule
